// File: rtl/remote_pos_axis_receiver.sv
// Remote position receiver: takes position/DONE packets off the network
// stream, filters them by destination node and payload validity, buffers
// accepted position records in a first-word-fall-through FIFO for the ring
// node, and signals when every remote position of the iteration has been
// delivered.
module remote_pos_axis_receiver #(
  parameter int FIFO_DEPTH              = 16,
  parameter int DROP_CNT_WIDTH          = 16,
  parameter int NODE_ID_WIDTH           = 4,
  parameter int STREAMING_TDEST_WIDTH   = 8,
  parameter int OFFSET_PKT_STRUCT_WIDTH = 24,
  parameter int GLOBAL_CELL_ID_WIDTH    = 3,
  parameter int NB_CELL_COUNT_WIDTH     = 8,
  parameter int AXIS_PKT_STRUCT_WIDTH   = OFFSET_PKT_STRUCT_WIDTH + 3*GLOBAL_CELL_ID_WIDTH
                                          + NB_CELL_COUNT_WIDTH + 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NODE_ID_WIDTH-1:0]            i_local_node_id,
  input  logic [AXIS_PKT_STRUCT_WIDTH-1:0]    i_axis_tdata,
  input  logic [STREAMING_TDEST_WIDTH-1:0]    i_axis_tdest,
  input  logic                                i_axis_tvalid,
  output logic                                o_axis_tready,
  output logic [OFFSET_PKT_STRUCT_WIDTH-1:0]  o_remote_offset_pkt,
  output logic [3*GLOBAL_CELL_ID_WIDTH-1:0]   o_remote_gcid,
  output logic [NB_CELL_COUNT_WIDTH-1:0]      o_remote_lifetime,
  output logic                                o_remote_valid,
  input  logic                                i_remote_ack,
  input  logic                                i_iter_start,
  output logic                                o_remote_done,
  output logic [DROP_CNT_WIDTH-1:0]           o_drop_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int GCID_W   = 3*GLOBAL_CELL_ID_WIDTH;
  localparam int GCID_LSB = OFFSET_PKT_STRUCT_WIDTH;
  localparam int LIFE_LSB = GCID_LSB + GCID_W;
  localparam int TYPE_LSB = LIFE_LSB + NB_CELL_COUNT_WIDTH;
  localparam int REC_W    = TYPE_LSB;  // stored record = everything below the type field

  localparam logic [1:0]                TYPE_POS  = 2'b00;
  localparam logic [1:0]                TYPE_DONE = 2'b01;
  localparam logic [AW:0]               DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]               ONE_CNT   = (AW+1)'(1);
  localparam logic [AW-1:0]             ONE_PTR   = AW'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE  = DROP_CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t                 state, state_next;
  logic [REC_W-1:0]       mem [FIFO_DEPTH];
  logic [REC_W-1:0]       head;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count, count_next;
  logic [1:0]             pkt_type;
  logic [NB_CELL_COUNT_WIDTH-1:0] lifetime;
  logic                   tdest_match, accept, push, done_pkt, drop, pop;

  // Only the low node-id bits of the destination are meaningful here.
  if (STREAMING_TDEST_WIDTH > NODE_ID_WIDTH) begin : g_tdest_hi
    logic unused_tdest_hi;
    assign unused_tdest_hi = ^i_axis_tdest[STREAMING_TDEST_WIDTH-1:NODE_ID_WIDTH];
  end

  assign pkt_type    = i_axis_tdata[TYPE_LSB +: 2];
  assign lifetime    = i_axis_tdata[LIFE_LSB +: NB_CELL_COUNT_WIDTH];
  assign tdest_match = (i_axis_tdest[NODE_ID_WIDTH-1:0] == i_local_node_id);

  // Ready uses registered occupancy only, so a pop never frees a slot for a
  // push in the same cycle; held low while reset is asserted.
  assign o_axis_tready = !rst && (state == S_IDLE) && (count < DEPTH_CNT);
  assign accept        = i_axis_tvalid && o_axis_tready;
  assign push          = accept && tdest_match && (pkt_type == TYPE_POS)
                         && (lifetime != '0);
  assign done_pkt      = accept && tdest_match && (pkt_type == TYPE_DONE);
  assign drop          = accept && !push && !done_pkt;
  assign pop           = i_remote_ack && o_remote_valid;

  // Head record falls through combinationally; masked to zero while empty.
  assign head                = mem[rd_ptr];
  assign o_remote_valid      = (count != '0);
  assign o_remote_offset_pkt = o_remote_valid ? head[0 +: OFFSET_PKT_STRUCT_WIDTH] : '0;
  assign o_remote_gcid       = o_remote_valid ? head[GCID_LSB +: GCID_W] : '0;
  assign o_remote_lifetime   = o_remote_valid ? head[LIFE_LSB +: NB_CELL_COUNT_WIDTH] : '0;
  assign o_remote_done       = (state == S_DONE);

  // Occupancy after this edge: push and pop together leave it unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_next = count;
    if (push && !pop)      count_next = count + ONE_CNT;
    else if (!push && pop) count_next = count - ONE_CNT;
  end

  // Next state: DONE packet starts the drain; drain ends the cycle the FIFO
  // empties; iteration start re-arms reception only from DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (done_pkt)            state_next = S_DRAIN;
      S_DRAIN: if (count_next == '0)    state_next = S_DONE;
      S_DONE:  if (i_iter_start)        state_next = S_IDLE;
      default:                          state_next = S_IDLE;
    endcase
  end

  // Control state: FSM, pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      o_drop_count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      if (drop && (o_drop_count != '1)) o_drop_count <= o_drop_count + DROP_ONE;
    end
  end

  // Record storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; outputs are masked while empty, so stale data never escapes.
    if (push) mem[wr_ptr] <= i_axis_tdata[REC_W-1:0];
  end

endmodule

// File: tb/tb_remote_pos_axis_receiver.sv
// Self-checking bench for remote_pos_axis_receiver: directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a queue-based reference model of the receiver.
module tb_remote_pos_axis_receiver;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  local_id = 4'd7;
  logic [42:0] tdata;
  logic [7:0]  tdest;
  logic        tvalid, ack, iter_start;

  logic        tready, r_valid, r_done;
  logic [23:0] r_off;
  logic [8:0]  r_gcid;
  logic [7:0]  r_life;
  logic [15:0] drop;

  logic        s_ready, s_valid, s_done;
  logic [23:0] unused_s_off;
  logic [8:0]  unused_s_gcid;
  logic [7:0]  unused_s_life;
  logic [1:0]  s_drop;

  remote_pos_axis_receiver dut (
    .clk(clk), .rst(rst), .i_local_node_id(local_id),
    .i_axis_tdata(tdata), .i_axis_tdest(tdest), .i_axis_tvalid(tvalid),
    .o_axis_tready(tready), .o_remote_offset_pkt(r_off), .o_remote_gcid(r_gcid),
    .o_remote_lifetime(r_life), .o_remote_valid(r_valid), .i_remote_ack(ack),
    .i_iter_start(iter_start), .o_remote_done(r_done), .o_drop_count(drop)
  );

  remote_pos_axis_receiver #(.DROP_CNT_WIDTH(2)) dut_small (
    .clk(clk), .rst(rst), .i_local_node_id(local_id),
    .i_axis_tdata(tdata), .i_axis_tdest(tdest), .i_axis_tvalid(tvalid),
    .o_axis_tready(s_ready), .o_remote_offset_pkt(unused_s_off), .o_remote_gcid(unused_s_gcid),
    .o_remote_lifetime(unused_s_life), .o_remote_valid(s_valid), .i_remote_ack(ack),
    .i_iter_start(iter_start), .o_remote_done(s_done), .o_drop_count(s_drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: record queue, phase (0 receive, 1 drain, 2 done), drop counts.
  logic [40:0] mq[$];
  int          phase;
  int          m_drop, m_drop_s;

  typedef struct {
    logic       valid;
    logic [1:0] ty;
    logic [7:0] life;
    logic [7:0] dest;
    logic       ack;
    logic       iter;
    logic       e_ready;
    logic       e_valid;
    logic       e_done;
    int         e_drop;
    int         e_drop_s;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [42:0] pkt(input logic [1:0] ty, input logic [7:0] life,
                                      input logic [8:0] gcid, input logic [23:0] off);
    return {ty, life, gcid, off};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [1:0] ty, input logic [7:0] life,
                               input logic [7:0] dest, input logic a, input logic it,
                               input logic er, input logic ev, input logic ed,
                               input int edr, input int eds);
    vec_t x;
    x.valid = v; x.ty = ty; x.life = life; x.dest = dest; x.ack = a; x.iter = it;
    x.e_ready = er; x.e_valid = ev; x.e_done = ed; x.e_drop = edr; x.e_drop_s = eds;
    return x;
  endfunction

  function automatic bit m_ready();
    return (phase == 0) && (mq.size() < DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    phase    = 0;
    m_drop   = 0;
    m_drop_s = 0;
  endtask

  task automatic model_step();
    logic [1:0] ty;
    logic [7:0] life;
    bit         acc, match;
    int         old;
    ty    = tdata[42:41];
    life  = tdata[40:33];
    match = (tdest[3:0] == local_id);
    acc   = tvalid && m_ready();
    old   = phase;
    if (ack && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      if (match && ty == 2'b00 && life != 8'd0) mq.push_back(tdata[40:0]);
      else if (!(match && ty == 2'b01)) begin
        if (m_drop < 65535) m_drop++;
        if (m_drop_s < 3)   m_drop_s++;
      end
    end
    if (old == 0 && acc && match && ty == 2'b01) phase = 1;
    else if (old == 1 && mq.size() == 0)         phase = 2;
    else if (old == 2 && iter_start)             phase = 0;
  endtask

  task automatic compare_all();
    logic [40:0] h;
    h = (mq.size() > 0) ? mq[0] : 41'd0;
    check("ready",   64'(tready),  64'(m_ready()));
    check("valid",   64'(r_valid), 64'(mq.size() > 0));
    check("done",    64'(r_done),  64'(phase == 2));
    check("drop",    64'(drop),    64'(m_drop));
    check("offset",  64'(r_off),   64'(h[23:0]));
    check("gcid",    64'(r_gcid),  64'(h[32:24]));
    check("life",    64'(r_life),  64'(h[40:33]));
    check("s_ready", 64'(s_ready), 64'(m_ready()));
    check("s_valid", 64'(s_valid), 64'(mq.size() > 0));
    check("s_done",  64'(s_done),  64'(phase == 2));
    check("s_drop",  64'(s_drop),  64'(m_drop_s));
  endtask

  // Called at posedge+1: compare, advance the model, move to next posedge+1.
  task automatic apply();
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tdata = '0; tdest = 8'd7; tvalid = 1'b0; ack = 1'b0; iter_start = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 rst = 1'b1;
    #1;
    check("rst_ready",  64'(tready),  64'd0);
    check("rst_valid",  64'(r_valid), 64'd0);
    check("rst_done",   64'(r_done),  64'd0);
    check("rst_drop",   64'(drop),    64'd0);
    check("rst_offset", 64'(r_off),   64'd0);
    check("rst_gcid",   64'(r_gcid),  64'd0);
    check("rst_life",   64'(r_life),  64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vector table (expected outputs are those seen during the row).
    vecs[0]  = mkv(0, 2'b00, 8'd3, 8'd7,    0, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mkv(1, 2'b00, 8'd3, 8'd7,    0, 0, 1, 0, 0, 0, 0);
    vecs[2]  = mkv(0, 2'b00, 8'd3, 8'd7,    0, 0, 1, 1, 0, 0, 0);
    vecs[3]  = mkv(0, 2'b00, 8'd3, 8'd7,    1, 0, 1, 1, 0, 0, 0);
    vecs[4]  = mkv(0, 2'b00, 8'd3, 8'd7,    0, 0, 1, 0, 0, 0, 0);
    vecs[5]  = mkv(1, 2'b00, 8'd3, 8'd5,    0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = mkv(1, 2'b00, 8'd0, 8'd7,    0, 0, 1, 0, 0, 1, 1);
    vecs[7]  = mkv(1, 2'b10, 8'd3, 8'd7,    0, 0, 1, 0, 0, 2, 2);
    vecs[8]  = mkv(0, 2'b00, 8'd3, 8'd7,    0, 0, 1, 0, 0, 3, 3);
    vecs[9]  = mkv(1, 2'b01, 8'd0, 8'd7,    0, 0, 1, 0, 0, 3, 3);
    vecs[10] = mkv(0, 2'b00, 8'd0, 8'd7,    0, 1, 0, 0, 0, 3, 3);
    vecs[11] = mkv(0, 2'b00, 8'd0, 8'd7,    0, 0, 0, 0, 1, 3, 3);
    vecs[12] = mkv(0, 2'b00, 8'd0, 8'd7,    0, 1, 0, 0, 1, 3, 3);
    vecs[13] = mkv(0, 2'b00, 8'd0, 8'd7,    0, 0, 1, 0, 0, 3, 3);
    vecs[14] = mkv(1, 2'b00, 8'd3, 8'h25,   0, 0, 1, 0, 0, 3, 3);
    vecs[15] = mkv(0, 2'b00, 8'd3, 8'd7,    0, 0, 1, 0, 0, 4, 3);
    vecs[16] = mkv(1, 2'b00, 8'd3, 8'hF7,   0, 0, 1, 0, 0, 4, 3);
    vecs[17] = mkv(0, 2'b00, 8'd3, 8'd7,    0, 0, 1, 1, 0, 4, 3);

    idle_inputs();
    do_reset();

    for (int i = 0; i < 18; i++) begin
      tvalid     = vecs[i].valid;
      tdata      = pkt(vecs[i].ty, vecs[i].life, 9'b010010010, 24'h030201);
      tdest      = vecs[i].dest;
      ack        = vecs[i].ack;
      iter_start = vecs[i].iter;
      #1;
      check($sformatf("vec%0d_ready", i),  64'(tready),  64'(vecs[i].e_ready));
      check($sformatf("vec%0d_valid", i),  64'(r_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_done", i),   64'(r_done),  64'(vecs[i].e_done));
      check($sformatf("vec%0d_drop", i),   64'(drop),    64'(vecs[i].e_drop));
      check($sformatf("vec%0d_sdrop", i),  64'(s_drop),  64'(vecs[i].e_drop_s));
      if (i == 2) begin
        check("pos_offset", 64'(r_off),  64'h030201);
        check("pos_gcid",   64'(r_gcid), 64'b010010010);
        check("pos_life",   64'(r_life), 64'd3);
      end
      apply();
    end

    // Fill to capacity without acks; 17th packet stalls until one pop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tvalid = 1'b1;
      tdata  = pkt(2'b00, 8'(i + 1), 9'h0AA, 24'(i));
      apply();
    end
    tdata = pkt(2'b00, 8'd17, 9'h0AA, 24'd16);
    #1 check("full_ready", 64'(tready), 64'd0);
    apply();
    apply();
    ack = 1'b1;
    apply();
    ack = 1'b0;
    #1 check("ready_after_ack", 64'(tready), 64'd1);
    apply();
    tvalid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      ack = 1'b1;
      #1 check($sformatf("order%0d", k), 64'(r_off), 64'(k));
      apply();
    end
    ack = 1'b0;
    #1 check("fill_empty", 64'(r_valid), 64'd0);
    apply();

    // Three records then DONE; ack every other cycle during the drain.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1;
      tdata  = pkt(2'b00, 8'(i + 1), 9'h111, 24'(24'h100 + i));
      apply();
    end
    tdata = pkt(2'b01, 8'd0, 9'd0, 24'd0);
    apply();
    tvalid = 1'b0;
    #1 check("drain_ready", 64'(tready), 64'd0);
    for (int c = 0; c < 6; c++) begin
      ack = (c % 2 == 0);
      #1;
      if (c == 4) check("done_before_last_pop", 64'(r_done), 64'd0);
      if (c == 5) check("done_after_last_pop",  64'(r_done), 64'd1);
      apply();
    end
    ack = 1'b0;
    iter_start = 1'b1;
    apply();
    iter_start = 1'b0;
    #1;
    check("iter_done",  64'(r_done), 64'd0);
    check("iter_ready", 64'(tready), 64'd1);
    apply();

    // Asynchronous reset with five records queued in DRAIN.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tvalid = 1'b1;
      tdest  = 8'd7;
      tdata  = pkt(2'b00, 8'd9, 9'h1FF, 24'hABCDE0 + 24'(i));
      apply();
    end
    tdest = 8'd3;
    apply();
    tdest = 8'd7;
    tdata = pkt(2'b01, 8'd0, 9'd0, 24'd0);
    apply();
    tvalid = 1'b0;
    #1;
    check("pre_rst_valid", 64'(r_valid), 64'd1);
    check("pre_rst_drop",  64'(drop),    64'd1);
    do_reset();
    #1;
    check("post_rst_ready", 64'(tready),  64'd1);
    check("post_rst_valid", 64'(r_valid), 64'd0);
    apply();

    // Randomized traffic with epochs of light and heavy acking.
    for (int c = 0; c < 3000; c++) begin
      int ack_pct;
      int r;
      logic [1:0] ty;
      logic [7:0] life;
      ack_pct = ((c / 300) % 3 == 0) ? 10 : 60;
      r       = int'($urandom_range(0, 99));
      ty      = (r < 86) ? 2'b00 : (r < 88) ? 2'b01 : (r < 94) ? 2'b10 : 2'b11;
      life    = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      tvalid  = ($urandom_range(0, 3) != 0);
      tdest   = ($urandom_range(0, 9) < 8) ? {4'($urandom), 4'd7} : 8'($urandom);
      tdata   = pkt(ty, life, 9'($urandom), 24'($urandom));
      ack     = ($urandom_range(0, 99) < ack_pct);
      iter_start = ($urandom_range(0, 3) == 0);
      apply();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
